// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: debounced two-switch controller stepping the LEDs through DIRECT/CHASE/BLINK/COUNT modes
module led_mode_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int TICK_LIMIT     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode
);
    localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam int TW = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;

    typedef enum logic [1:0] {DIRECT, CHASE, BLINK, COUNT} mode_t;

    logic [1:0]    r_meta, r_sync, r_stable, r_stable_d;
    logic [DW-1:0] r_db_cnt [2];
    logic [1:0]    w_press;
    mode_t         r_mode, w_mode_n;
    logic          r_pause, w_pause_n, w_tick;
    logic [TW-1:0] r_presc, w_presc_n;
    logic [3:0]    r_pattern, w_pattern_n;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta     <= '0;
            r_sync     <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_db_cnt   <= '{default: '0};
        end else begin
            r_meta     <= {i_Switch_2, i_Switch_1};
            r_sync     <= r_meta;
            r_stable_d <= r_stable;
            for (int k = 0; k < 2; k++)
                if (r_sync[k] == r_stable[k])
                    r_db_cnt[k] <= '0;
                else if (r_db_cnt[k] == DW'(DEBOUNCE_LIMIT - 1)) begin
                    r_stable[k] <= r_sync[k];
                    r_db_cnt[k] <= '0;
                end else
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
    end

    // Press events fire the cycle after a debounced 0->1; releases are ignored
    assign w_press = r_stable & ~r_stable_d;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_mode    <= DIRECT;
            r_pause   <= 1'b0;
            r_presc   <= '0;
            r_pattern <= 4'b0000;
            {o_LED_4, o_LED_3, o_LED_2, o_LED_1} <= 4'b0000;
            o_Mode    <= 2'd0;
        end else begin
            r_mode    <= w_mode_n;
            r_pause   <= w_pause_n;
            r_presc   <= w_presc_n;
            r_pattern <= w_pattern_n;
            {o_LED_4, o_LED_3, o_LED_2, o_LED_1} <= (r_mode == DIRECT) ? {2'b00, r_stable} : r_pattern;
            o_Mode    <= r_mode;
        end
    end

    // A mode advance overrides both a pending pause toggle and a coincident tick
    always_comb begin
        w_mode_n    = r_mode;
        w_pause_n   = r_pause;
        w_presc_n   = r_presc;
        w_pattern_n = r_pattern;
        w_tick      = 1'b0;
        if (w_press[0]) begin
            w_mode_n    = mode_t'(r_mode + 2'd1);
            w_pause_n   = 1'b0;
            w_presc_n   = '0;
            w_pattern_n = (w_mode_n == CHASE) ? 4'b0001 : 4'b0000;
        end else if (r_mode == DIRECT)
            w_presc_n = '0;
        else begin
            w_pause_n = r_pause ^ w_press[1];
            if (!r_pause) begin
                w_tick    = (r_presc == TW'(TICK_LIMIT - 1));
                w_presc_n = w_tick ? '0 : r_presc + 1'b1;
                if (w_tick)
                    w_pattern_n = (r_mode == CHASE) ? {r_pattern[2:0], r_pattern[3]} :
                                  (r_mode == BLINK) ? ~r_pattern : r_pattern + 4'd1;
            end
        end
    end
endmodule
